register_bank: RTL and testbench

Parametrised bank of DEPTH general-purpose registers, each WIDTH bits, replacing single-register instances in the processor datapath. Each clock it performs one read-modify-write operation (load, increment, decrement, shift, clear) on one addressed register and keeps zero/carry flags from that operation. Two independent read ports feed the ALU operand buses, with an optional same-cycle write bypass.

---
 rtl/register_bank.sv | 106 ++++++++++
 tb/tb_register_bank.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_bank.sv
// Bank of DEPTH registers with one read-modify-write operation per clock,
// zero/carry flags from the last executed operation, and two combinational read ports.
module register_bank #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int BYPASS = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ce,
  input  logic                       we,
  input  logic [2:0]                 op,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [WIDTH-1:0]           in,
  input  logic [$clog2(DEPTH)-1:0]   raddr_a,
  input  logic [$clog2(DEPTH)-1:0]   raddr_b,
  output logic [WIDTH-1:0]           out_a,
  output logic [WIDTH-1:0]           out_b,
  output logic                       zero,
  output logic                       carry
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [2:0] OP_LOAD = 3'd0;
  localparam logic [2:0] OP_INC  = 3'd1;
  localparam logic [2:0] OP_DEC  = 3'd2;
  localparam logic [2:0] OP_SHL  = 3'd3;
  localparam logic [2:0] OP_SHR  = 3'd4;
  localparam logic [2:0] OP_CLR  = 3'd5;

  logic [WIDTH-1:0] regs [DEPTH];
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] stored_a;
  logic [WIDTH-1:0] stored_b;
  logic             nxt_carry;
  logic             op_valid;
  logic             addr_valid;
  logic             exec;

  // Target register value; addresses past DEPTH match nothing and mark the write invalid.
  always_comb begin
    cur        = '0;
    addr_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (waddr == AW'(i)) begin
        cur        = regs[i];
        addr_valid = 1'b1;
      end
    end
  end

  // Operation result and its carry/borrow/shifted-out bit.
  always_comb begin
    nxt       = cur;
    nxt_carry = 1'b0;
    op_valid  = 1'b1;
    case (op)
      OP_LOAD: nxt = in;
      OP_INC:  {nxt_carry, nxt} = {1'b0, cur} + (WIDTH+1)'(1);
      OP_DEC:  {nxt_carry, nxt} = {1'b0, cur} - (WIDTH+1)'(1);
      OP_SHL: begin
        nxt       = {cur[WIDTH-2:0], 1'b0};
        nxt_carry = cur[WIDTH-1];
      end
      OP_SHR: begin
        nxt       = {1'b0, cur[WIDTH-1:1]};
        nxt_carry = cur[0];
      end
      OP_CLR:  nxt = '0;
      default: op_valid = 1'b0;
    endcase
  end

  // Reset is included so a bypassed read cannot leak a value while rst is low.
  assign exec = rst & ce & we & op_valid & addr_valid;

  always_comb begin
    stored_a = '0;
    stored_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr_a == AW'(i)) stored_a = regs[i];
      if (raddr_b == AW'(i)) stored_b = regs[i];
    end
  end

  assign out_a = (BYPASS != 0 && exec && raddr_a == waddr) ? nxt : stored_a;
  assign out_b = (BYPASS != 0 && exec && raddr_b == waddr) ? nxt : stored_b;

  // Register file and flags; everything holds unless an operation executes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      zero  <= 1'b0;
      carry <= 1'b0;
    end else if (exec) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (waddr == AW'(i)) regs[i] <= nxt;
      end
      zero  <= (nxt == '0);
      carry <= nxt_carry;
    end
  end

endmodule

// File: tb/tb_register_bank.sv
// Randomized bench for register_bank: three instances (plain, bypass, DEPTH=5) share stimulus
// and are compared every cycle against an arithmetic model, plus directed literal checks.
module tb_register_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce = 1'b0;
  logic       we = 1'b0;
  logic [2:0] op = 3'd0;
  logic [2:0] waddr = 3'd0;
  logic [2:0] raddr_a = 3'd0;
  logic [2:0] raddr_b = 3'd0;
  logic [7:0] din = 8'd0;

  logic [7:0] oa [3];
  logic [7:0] ob [3];
  logic       zr [3];
  logic       cy [3];

  int checks = 0;
  int errors = 0;

  logic [7:0] m_reg [3][8];
  logic       m_zero [3];
  logic       m_carry [3];

  always #5 clk = ~clk;

  register_bank #(.WIDTH(8), .DEPTH(8), .BYPASS(0)) u_plain (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .op(op), .waddr(waddr), .in(din),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .out_a(oa[0]), .out_b(ob[0]), .zero(zr[0]), .carry(cy[0]));
  register_bank #(.WIDTH(8), .DEPTH(8), .BYPASS(1)) u_bypass (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .op(op), .waddr(waddr), .in(din),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .out_a(oa[1]), .out_b(ob[1]), .zero(zr[1]), .carry(cy[1]));
  register_bank #(.WIDTH(8), .DEPTH(5), .BYPASS(0)) u_depth5 (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .op(op), .waddr(waddr), .in(din),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .out_a(oa[2]), .out_b(ob[2]), .zero(zr[2]), .carry(cy[2]));

  function automatic int dep(input int k);
    return (k == 2) ? 5 : 8;
  endfunction

  function automatic bit byp(input int k);
    return (k == 1);
  endfunction

  // Operation semantics as plain arithmetic on the current inputs.
  function automatic void apply_op(input logic [7:0] r, output logic [7:0] n, output logic c,
                                   output bit valid);
    int v;
    v = int'(r);
    valid = 1'b1;
    c = 1'b0;
    n = r;
    case (op)
      3'd0: n = din;
      3'd1: begin n = 8'((v + 1) % 256); c = (v == 255); end
      3'd2: begin n = 8'((v + 255) % 256); c = (v == 0); end
      3'd3: begin n = 8'((v * 2) % 256); c = (v >= 128); end
      3'd4: begin n = 8'(v / 2); c = (v % 2 == 1); end
      3'd5: n = 8'd0;
      default: valid = 1'b0;
    endcase
  endfunction

  function automatic bit exec_m(input int k);
    logic [7:0] n;
    logic c;
    bit v;
    apply_op(m_reg[k][waddr], n, c, v);
    return rst && ce && we && v && (int'(waddr) < dep(k));
  endfunction

  function automatic logic [7:0] exp_read(input int k, input logic [2:0] a);
    logic [7:0] n;
    logic c;
    bit v;
    if (int'(a) >= dep(k)) return 8'd0;
    if (byp(k) && exec_m(k) && a == waddr) begin
      apply_op(m_reg[k][waddr], n, c, v);
      return n;
    end
    return m_reg[k][a];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 8; i++) m_reg[k][i] = 8'd0;
      m_zero[k] = 1'b0;
      m_carry[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    logic [7:0] n;
    logic c;
    bit v;
    for (int k = 0; k < 3; k++) begin
      if (!rst) begin
        for (int i = 0; i < 8; i++) m_reg[k][i] = 8'd0;
        m_zero[k] = 1'b0;
        m_carry[k] = 1'b0;
      end else if (exec_m(k)) begin
        apply_op(m_reg[k][waddr], n, c, v);
        m_reg[k][waddr] = n;
        m_zero[k] = (n == 8'd0);
        m_carry[k] = c;
      end
    end
  endtask

  task automatic chk(input string name, input int k, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d got %h want %h at %0t", name, k, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 3; k++) begin
      chk("out_a", k, oa[k], exp_read(k, raddr_a));
      chk("out_b", k, ob[k], exp_read(k, raddr_b));
      chk("zero", k, {7'd0, zr[k]}, {7'd0, m_zero[k]});
      chk("carry", k, {7'd0, cy[k]}, {7'd0, m_carry[k]});
    end
  endtask

  task automatic drive(input logic c, input logic w, input logic [2:0] o, input logic [2:0] wa,
                       input logic [7:0] d, input logic [2:0] ra, input logic [2:0] rb);
    ce = c; we = w; op = o; waddr = wa; din = d; raddr_a = ra; raddr_b = rb;
    #1;
  endtask

  // Mid-cycle compare against the model, then advance the model across the rising edge.
  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    model_reset();
    #2 rst = 1'b0;
    model_reset();
    drive(0, 0, 0, 0, 8'h00, 0, 0);
    tick();
    tick();
    rst = 1'b1;

    // Reset pulse between edges
    drive(1, 1, 3'd0, 3'd3, 8'hA5, 3'd3, 3'd3);
    tick();
    drive(0, 0, 3'd0, 3'd0, 8'h00, 3'd3, 3'd3);
    chk("r3_loaded", 0, oa[0], 8'hA5);
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_out_a", 0, oa[0], 8'h00);
    chk("rst_zero", 0, {7'd0, zr[0]}, 8'h00);
    chk("rst_carry", 0, {7'd0, cy[0]}, 8'h00);
    rst = 1'b1;
    tick();

    // LOAD then hold through ce=0 and a NOP
    drive(1, 1, 3'd0, 3'd1, 8'h3C, 3'd1, 3'd1);
    tick();
    drive(0, 1, 3'd0, 3'd1, 8'hFF, 3'd1, 3'd1);
    tick();
    tick();
    drive(1, 1, 3'd6, 3'd1, 8'hFF, 3'd1, 3'd1);
    chk("hold_ce0", 1, oa[1], 8'h3C);
    tick();
    chk("hold_nop", 0, oa[0], 8'h3C);
    chk("hold_zero", 0, {7'd0, zr[0]}, 8'h00);

    // Wrap on INC and DEC
    drive(1, 1, 3'd0, 3'd2, 8'hFF, 3'd2, 3'd2);
    tick();
    drive(1, 1, 3'd1, 3'd2, 8'h00, 3'd2, 3'd2);
    tick();
    drive(1, 1, 3'd2, 3'd2, 8'h00, 3'd2, 3'd2);
    chk("inc_wrap", 0, oa[0], 8'h00);
    chk("inc_zero", 0, {7'd0, zr[0]}, 8'h01);
    chk("inc_carry", 0, {7'd0, cy[0]}, 8'h01);
    tick();
    drive(0, 0, 3'd0, 3'd0, 8'h00, 3'd2, 3'd2);
    chk("dec_wrap", 0, oa[0], 8'hFF);
    chk("dec_zero", 0, {7'd0, zr[0]}, 8'h00);
    chk("dec_borrow", 0, {7'd0, cy[0]}, 8'h01);
    tick();

    // Shifts
    drive(1, 1, 3'd0, 3'd0, 8'h81, 3'd0, 3'd0);
    tick();
    drive(1, 1, 3'd3, 3'd0, 8'h00, 3'd0, 3'd0);
    tick();
    drive(1, 1, 3'd4, 3'd0, 8'h00, 3'd0, 3'd0);
    chk("shl_val", 0, oa[0], 8'h02);
    chk("shl_carry", 0, {7'd0, cy[0]}, 8'h01);
    tick();
    drive(1, 1, 3'd4, 3'd0, 8'h00, 3'd0, 3'd0);
    chk("shr_val", 0, oa[0], 8'h01);
    chk("shr_carry", 0, {7'd0, cy[0]}, 8'h00);
    tick();
    drive(0, 0, 3'd0, 3'd0, 8'h00, 3'd0, 3'd0);
    chk("shr2_val", 0, oa[0], 8'h00);
    chk("shr2_zero", 0, {7'd0, zr[0]}, 8'h01);
    chk("shr2_carry", 0, {7'd0, cy[0]}, 8'h01);
    tick();

    // Dual read with and without bypass
    drive(1, 1, 3'd0, 3'd4, 8'h11, 3'd4, 3'd4);
    tick();
    drive(1, 1, 3'd1, 3'd4, 8'h00, 3'd4, 3'd4);
    chk("nobyp_a_pre", 0, oa[0], 8'h11);
    chk("nobyp_b_pre", 0, ob[0], 8'h11);
    chk("byp_a_pre", 1, oa[1], 8'h12);
    chk("byp_b_pre", 1, ob[1], 8'h12);
    tick();
    drive(0, 0, 3'd0, 3'd0, 8'h00, 3'd4, 3'd4);
    chk("nobyp_a_post", 0, oa[0], 8'h12);
    chk("nobyp_b_post", 0, ob[0], 8'h12);
    tick();

    // Out-of-range write and read on the DEPTH=5 instance
    drive(1, 1, 3'd0, 3'd0, 8'h00, 3'd7, 3'd6);
    tick();
    drive(1, 1, 3'd0, 3'd6, 8'hAA, 3'd7, 3'd6);
    chk("d5_raddr7", 2, oa[2], 8'h00);
    tick();
    drive(0, 0, 3'd0, 3'd0, 8'h00, 3'd7, 3'd6);
    chk("d5_r6", 2, ob[2], 8'h00);
    chk("d5_zero_held", 2, {7'd0, zr[2]}, 8'h01);
    chk("d8_r6", 0, ob[0], 8'hAA);
    chk("d8_zero", 0, {7'd0, zr[0]}, 8'h00);
    tick();

    // Randomized traffic with chaining, edge data values and occasional resets
    for (int n = 0; n < 1500; n++) begin
      logic [7:0] d;
      logic [2:0] wa;
      case ($urandom_range(0, 3))
        0: d = 8'h00;
        1: d = 8'hFF;
        2: d = 8'h80 | 8'($urandom_range(0, 1));
        default: d = 8'($urandom);
      endcase
      wa = ($urandom_range(0, 1) == 0) ? waddr : 3'($urandom_range(0, 7));
      drive(($urandom_range(0, 7) != 0), ($urandom_range(0, 5) != 0), 3'($urandom_range(0, 7)),
            wa, d, ($urandom_range(0, 1) == 0) ? wa : 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)));
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b0;
        model_reset();
        #1;
        if ($urandom_range(0, 1) == 0) rst = 1'b1;
      end
      tick();
      rst = 1'b1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
